// File: rtl/sram_pkg.sv
// Shared state encoding and counter sizing
// for the 16-bit asynchronous SRAM PHY.
package sram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'b001,
    ST_ACCESS = 3'b010,
    ST_DONE   = 3'b100
  } state_t;

  localparam int CNT_W = 4;

endpackage

// File: rtl/sram_phy_16.sv
// 16-bit async SRAM PHY: IDLE/turnaround, timed
// strobe window, then one cycle of address/data hold.
module sram_phy_16
  import sram_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int RD_CYCLES = 2,
  parameter int WR_CYCLES = 2
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] address_16,
  input  logic [1:0]        byteena_16,
  input  logic [15:0]       data_16,
  input  logic              wren_16,
  input  logic              ce_16,
  output logic [15:0]       q_16,
  output logic              wait_16,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_dq_o,
  output logic              sram_dq_oe,
  input  logic [15:0]       sram_dq_i,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_lb_n,
  output logic              sram_ub_n
);

  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_CYCLES - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_CYCLES - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [15:0]         dq_o_q, dq_o_d;
  logic [15:0]         q_q, q_d;
  logic                dq_oe_q, dq_oe_d;
  logic                ce_n_q, ce_n_d;
  logic                oe_n_q, oe_n_d;
  logic                we_n_q, we_n_d;
  logic                lb_n_q, lb_n_d;
  logic                ub_n_q, ub_n_d;

  // Strobe registers are loaded with the value
  // the next state needs, so pads change on entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    dq_o_d  = dq_o_q;
    q_d     = q_q;
    dq_oe_d = dq_oe_q;
    ce_n_d  = ce_n_q;
    oe_n_d  = oe_n_q;
    we_n_d  = we_n_q;
    lb_n_d  = lb_n_q;
    ub_n_d  = ub_n_q;
    unique case (state_q)
      ST_IDLE: begin
        if (ce_16) begin
          state_d = ST_ACCESS;
          addr_d  = address_16;
          wr_d    = wren_16;
          cnt_d   = wren_16 ? WR_LOAD : RD_LOAD;
          ce_n_d  = 1'b0;
          if (wren_16) begin
            dq_o_d  = data_16;
            dq_oe_d = 1'b1;
            we_n_d  = 1'b0;
            lb_n_d  = ~byteena_16[0];
            ub_n_d  = ~byteena_16[1];
          end else begin
            oe_n_d = 1'b0;
            lb_n_d = 1'b0;
            ub_n_d = 1'b0;
          end
        end
      end
      ST_ACCESS: begin
        if (cnt_q == '0) begin
          state_d = ST_DONE;
          we_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          if (!wr_q) q_d = sram_dq_i;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        lb_n_d  = 1'b1;
        ub_n_d  = 1'b1;
        dq_oe_d = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        lb_n_d  = 1'b1;
        ub_n_d  = 1'b1;
        dq_oe_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      dq_o_q  <= '0;
      q_q     <= '0;
      dq_oe_q <= 1'b0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      lb_n_q  <= 1'b1;
      ub_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      dq_o_q  <= dq_o_d;
      q_q     <= q_d;
      dq_oe_q <= dq_oe_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      lb_n_q  <= lb_n_d;
      ub_n_q  <= ub_n_d;
    end
  end

  assign wait_16    = ce_16 & (state_q != ST_DONE);
  assign q_16       = q_q;
  assign sram_addr  = addr_q;
  assign sram_dq_o  = dq_o_q;
  assign sram_dq_oe = dq_oe_q;
  assign sram_ce_n  = ce_n_q;
  assign sram_oe_n  = oe_n_q;
  assign sram_we_n  = we_n_q;
  assign sram_lb_n  = lb_n_q;
  assign sram_ub_n  = ub_n_q;

endmodule

// File: doc/sram_phy_16.md
Name: sram_phy_16

Overview:
- Drives an external asynchronous 16-bit SRAM (CE#/OE#/WE#/LB#/UB#) from the 16-bit request interface produced by the 32-to-16 bus converter.
- Sits directly downstream of that converter: consumes address_16/byteena_16/data_16/wren_16/ce_16 and returns q_16/wait_16.
- Generates SRAM access timing in whole clock cycles.
- All pad outputs are registered.

Parameters:
- ADDR_W, 10, SRAM word-address width.
- RD_CYCLES, 2, cycles OE# stays low per read (legal range 1..15).
- WR_CYCLES, 2, cycles WE# stays low per write (legal range 1..15).

Ports:
- clock  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- address_16  in  ADDR_W  word address.
- byteena_16  in  2  byte enables; [1]=upper byte, [0]=lower byte.
- data_16  in  16  write data.
- wren_16  in  1  1=write, 0=read.
- ce_16  in  1  request valid.
- q_16  out  16  read data.
- wait_16  out  1  access not yet complete.
- sram_addr  out  ADDR_W  pad address.
- sram_dq_o  out  16  pad write data.
- sram_dq_oe  out  1  pad data output enable.
- sram_dq_i  in  16  pad read data.
- sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n  out  1 each  active-low SRAM strobes.

Behaviour:
- Clock and reset: one clock, clock. rst_n is asynchronous and active-low.
- Reset values: sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n = 1; sram_dq_oe = 0; sram_addr = 0; sram_dq_o = 0; q_16 = 0; state = IDLE. These apply immediately on rst_n falling, including mid-access. No clock is needed. An interrupted write is simply lost.
- Handshake: a transfer completes on the clock edge where ce_16=1 and wait_16=0. The requester holds all request inputs stable while wait_16=1.
- wait_16 = ce_16 & (state != DONE). It is combinational, so wait_16 rises in the same cycle ce_16 rises.
- States are one-hot: IDLE, ACCESS, DONE.
- IDLE:
  - All strobes inactive and sram_dq_oe=0. This cycle doubles as bus turnaround.
  - If ce_16=1, capture the request:
    - sram_addr <= address_16.
    - Write: sram_dq_o <= data_16.
    - Load the 4-bit counter with (wren_16 ? WR_CYCLES : RD_CYCLES) - 1.
    - Go to ACCESS.
- ACCESS:
  - sram_ce_n=0.
  - Read: sram_oe_n=0 and sram_lb_n=sram_ub_n=0. byteena_16 is ignored for reads; the full word is always returned.
  - Write: sram_we_n=0, sram_dq_oe=1, sram_lb_n=~byteena_16[0], sram_ub_n=~byteena_16[1].
  - The counter decrements each cycle.
  - When the counter is 0, go to DONE. A read captures sram_dq_i into the q_16 register on that same edge.
  - ACCESS therefore lasts exactly RD_CYCLES or WR_CYCLES cycles.
- DONE:
  - sram_we_n=1 and sram_oe_n=1.
  - sram_ce_n=0, sram_addr, sram_dq_o and sram_dq_oe are held, giving one cycle of address/data hold after WE# rises.
  - wait_16=0. For a read, q_16 holds the captured word.
  - Unconditionally go to IDLE next.
- q_16 holds the last read value in all states. Writes do not change it.
- Latency: ce_16 rising to the completion edge is 1+N+1 cycles, where N = RD_CYCLES or WR_CYCLES. Back-to-back requests cost N+2 cycles each.
- byteena_16=2'b00 on a write: the full access timing runs with LB#/UB# both high, so no byte is written.
- ce_16 dropped during ACCESS (protocol violation): the access still runs to completion. wait_16 reads 0 because ce_16=0. No abort.
- ce_16 dropped in IDLE: no access is started.

Decomposition:
- Package sram_pkg:
  - One-hot state constants ST_IDLE=3'b001, ST_ACCESS=3'b010, ST_DONE=3'b100.
  - Counter width constant CNT_W=4.
- No sub-module inside this block. The tri-state merge of sram_dq_o/sram_dq_oe/sram_dq_i into the inout pad lives in the top-level pad ring, not here.

Test Plan (RD_CYCLES=2, WR_CYCLES=2, cycle 0 = first cycle ce_16=1; SRAM model responds combinationally):
1. Reset: assert rst_n=0 asynchronously -> all strobes 1, sram_dq_oe=0, q_16=0, wait_16=0 with ce_16=0. Release -> state IDLE.
2. Write addr 0x155, data 0xA5C3, byteena 2'b11 ->
   - wait_16=1 in cycles 0-2.
   - Cycles 1-2: sram_we_n=0, sram_addr=0x155, sram_dq_o=0xA5C3, sram_dq_oe=1, lb_n=ub_n=0.
   - Cycle 3: DONE, wait_16=0, sram_we_n=1, sram_dq_oe still 1.
   - Cycle 4: all strobes inactive.
3. Read addr 0x155 -> sram_oe_n=0 in cycles 1-2; q_16=0xA5C3 with wait_16=0 in cycle 3; q_16 unchanged afterwards.
4. Byte write addr 0x155, data 0x7E00, byteena 2'b10 -> sram_ub_n=0, sram_lb_n=1. Subsequent read returns 0x7EC3.
5. Converter-style pair: read 0x2A0 then read 0x2A1 with ce_16 held high -> completion edges at cycles 3 and 7. q_16 returns each word in its DONE cycle. sram_ce_n=1 in cycle 4.
6. rst_n driven low in cycle 1 of a write -> sram_we_n=1, sram_ce_n=1, sram_dq_oe=0 before the next clock edge. After release: IDLE, and wait_16 follows ce_16.
